mem_lsu_stage: RTL and testbench



---
 rtl/mem_lsu_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_lsu_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_stage.sv
// Memory stage: issues loads/stores on a req/gnt/rvalid port, stalls while an
// access is outstanding, extends load data and registers the MEM/WB outputs.
//
// Memory port handshake: data_req_o is held high, with address, write enable,
// byte enables and store data stable, until the cycle data_gnt_i is seen high.
// A read returns with data_rvalid_i in a later cycle; rvalid seen in the grant
// cycle, or outside an outstanding read, is ignored.
module mem_lsu_stage #(
    parameter int XLEN    = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [2:0]        funct3_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [XLEN-1:0]   alu_rst_i,
    input  logic [XLEN-1:0]   mem_wdata_i,
    output logic              stall_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_i,
    output logic              valid_o,
    output logic              memtoreg_o,
    output logic              regwrite_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [XLEN-1:0]   alu_rst_o,
    output logic [XLEN-1:0]   mem_rdata_o,
    output logic              misalign_o,
    output logic              timeout_o,
    output logic [1:0]        state_o
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [31:0] TO_LIM = TIMEOUT;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RV  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            mem_op;
    logic            is_load;
    logic            misalign;
    logic            mis_size;
    logic [2:0]      align_mask;
    logic [NB-1:0]   be_base;
    logic [LW-1:0]   lane;
    logic            expire;
    logic            misalign_evt;
    logic            timeout_evt;
    logic            load_done;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] load_ext;

    assign mem_op  = valid_i & (memread_i | memwrite_i);
    assign is_load = memread_i & ~memwrite_i;
    assign lane    = alu_rst_i[LW-1:0];
    assign state_o = state;

    // The wait limit counts the cycle the wait began (issue or grant cycle).
    assign expire = (TO_LIM != 32'd0) &&
                    (({{(32-CW){1'b0}}, cnt} + 32'd2) >= TO_LIM);

    // Size decode: alignment mask, base byte enables, illegal sizes.
    always_comb begin
        mis_size   = 1'b0;
        align_mask = 3'd0;
        be_base    = '0;
        case (funct3_i[1:0])
            2'b00: begin align_mask = 3'd0; be_base = NB'(1);  end
            2'b01: begin align_mask = 3'd1; be_base = NB'(3);  end
            2'b10: begin align_mask = 3'd3; be_base = NB'(15); end
            default: begin
                align_mask = 3'd7;
                be_base    = '1;
                mis_size   = (XLEN == 32);
            end
        endcase
        if (funct3_i == 3'b111) mis_size = 1'b1;
        misalign = mis_size | ((3'(lane) & align_mask) != 3'd0);
    end

    // Extend the addressed lane of the read word.
    always_comb begin
        sh = data_i >> {lane, 3'b000};
        case (funct3_i)
            3'b000:  load_ext = XLEN'($signed(sh[7:0]));
            3'b001:  load_ext = XLEN'($signed(sh[15:0]));
            3'b010:  load_ext = XLEN'($signed(sh[31:0]));
            3'b100:  load_ext = XLEN'(sh[7:0]);
            3'b101:  load_ext = XLEN'(sh[15:0]);
            3'b110:  load_ext = XLEN'(sh[31:0]);
            default: load_ext = sh;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Wait counter: cleared whenever the state changes, counts while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     cnt <= '0;
        else if (state_nxt == IDLE || state_nxt != state) cnt <= '0;
        else                                          cnt <= cnt + 1'b1;
    end

    // Next-state logic; a grant or rvalid beats an expiring timer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_op && !misalign) begin
                    if (!data_gnt_i)   state_nxt = WAIT_GNT;
                    else if (is_load)  state_nxt = WAIT_RV;
                end
            end
            WAIT_GNT: begin
                if (data_gnt_i)   state_nxt = is_load ? WAIT_RV : IDLE;
                else if (expire)  state_nxt = IDLE;
            end
            WAIT_RV: begin
                if (data_rvalid_i || expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-port drive, stall and completion events.
    always_comb begin
        data_req_o   = rst & (((state == IDLE) & mem_op & ~misalign) |
                              (state == WAIT_GNT));
        stall_o      = rst & (state_nxt != IDLE);
        data_we_o    = data_req_o & ~is_load;
        data_be_o    = be_base << lane;
        data_addr_o  = {alu_rst_i[XLEN-1:LW], {LW{1'b0}}};
        data_o       = mem_wdata_i << {lane, 3'b000};
        misalign_evt = (state == IDLE) & mem_op & misalign;
        timeout_evt  = expire & (((state == WAIT_GNT) & ~data_gnt_i) |
                                 ((state == WAIT_RV) & ~data_rvalid_i));
        load_done    = (state == WAIT_RV) & data_rvalid_i;
    end

    // MEM/WB register: capture on completion, bubble while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o     <= 1'b0;
            memtoreg_o  <= 1'b0;
            regwrite_o  <= 1'b0;
            rd_o        <= '0;
            alu_rst_o   <= '0;
            mem_rdata_o <= '0;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else if (state_nxt == IDLE) begin
            valid_o     <= valid_i;
            memtoreg_o  <= memtoreg_i & valid_i & ~misalign_evt & ~timeout_evt;
            regwrite_o  <= regwrite_i & valid_i & ~misalign_evt & ~timeout_evt;
            rd_o        <= rd_i;
            alu_rst_o   <= alu_rst_i;
            mem_rdata_o <= load_done ? load_ext : '0;
            misalign_o  <= misalign_evt;
            timeout_o   <= timeout_evt;
        end else begin
            valid_o     <= 1'b0;
            memtoreg_o  <= 1'b0;
            regwrite_o  <= 1'b0;
            mem_rdata_o <= '0;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: directed cases then randomized ops against a
// transaction-level model of latency, port drive and write-back contents.
module tb_mem_lsu_stage;

    localparam int XLEN = 32;
    localparam int RD_W = 5;
    localparam int TO   = 4;

    logic              clk;
    logic              rst;
    logic              valid_i, memread_i, memwrite_i, regwrite_i, memtoreg_i;
    logic [2:0]        funct3_i;
    logic [RD_W-1:0]   rd_i;
    logic [XLEN-1:0]   alu_rst_i, mem_wdata_i;
    logic              stall_o, data_req_o, data_we_o;
    logic [XLEN/8-1:0] data_be_o;
    logic [XLEN-1:0]   data_addr_o, data_o;
    logic              data_gnt_i, data_rvalid_i;
    logic [XLEN-1:0]   data_i;
    logic              valid_o, memtoreg_o, regwrite_o;
    logic [RD_W-1:0]   rd_o;
    logic [XLEN-1:0]   alu_rst_o, mem_rdata_o;
    logic              misalign_o, timeout_o;
    logic [1:0]        state_o;

    mem_lsu_stage #(.XLEN(XLEN), .RD_W(RD_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .funct3_i(funct3_i),
        .rd_i(rd_i), .alu_rst_i(alu_rst_i), .mem_wdata_i(mem_wdata_i),
        .stall_o(stall_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_o(data_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_i(data_i),
        .valid_o(valid_o), .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o),
        .rd_o(rd_o), .alu_rst_o(alu_rst_o), .mem_rdata_o(mem_rdata_o),
        .misalign_o(misalign_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            valid;
        logic            regwrite;
        logic            memtoreg;
        logic            chk_mtr;
        logic            misalign;
        logic            timeout;
        logic            chk_rdata;
        logic [RD_W-1:0] rd;
        logic [31:0]     alu;
        logic [31:0]     rdata;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model rules: access size, alignment legality, load extension.
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b111) return 1'b1;
        if (size_bytes(f3) > XLEN / 8) return 1'b1;
        return (addr % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data);
        int n;
        int off;
        logic [63:0] v;
        n   = size_bytes(f3);
        off = addr % 4;
        v   = ({32'd0, data} >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
        if (!f3[2] && (((v >> (8 * n - 1)) & 64'd1) != 0)) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic check_wb();
        wb_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wb_valid", valid_o, e.valid);
            check("wb_rd", rd_o, e.rd);
            check("wb_alu", alu_rst_o, e.alu);
            check("wb_regwrite", regwrite_o, e.regwrite);
            check("wb_misalign", misalign_o, e.misalign);
            check("wb_timeout", timeout_o, e.timeout);
            if (e.chk_mtr)   check("wb_memtoreg", memtoreg_o, e.memtoreg);
            if (e.chk_rdata) check("wb_rdata", mem_rdata_o, e.rdata);
        end
    endtask

    // Drive one instruction; the memory side grants in cycle g and returns
    // read data r cycles after the grant (stray: extra rvalid in grant cycle).
    task automatic do_op(input bit v, input bit rd_en, input bit wr_en, input bit rw,
                         input bit mtr, input logic [2:0] f3, input logic [RD_W-1:0] rd,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int g, input int r, input bit stray, input logic [31:0] rdata);
        bit   mem, load, mis, aligned, to;
        int   k, gc, n, off;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        wb_t  e;
        mem     = v && (rd_en || wr_en);
        load    = rd_en && !wr_en;
        mis     = mem && is_misaligned(f3, addr);
        aligned = mem && !mis;
        to      = 1'b0;
        n       = size_bytes(f3);
        off     = addr % 4;
        exp_be  = 4'(((32'd1 << n) - 32'd1) << off);
        exp_wd  = wdata << (8 * off);
        if (!aligned) begin
            k = 0; gc = -1;
        end else if (g > TO - 1) begin
            to = 1'b1; k = TO - 1; gc = TO - 1;
        end else begin
            gc = g;
            if (!load)          k = g;
            else if (r > TO - 1) begin to = 1'b1; k = g + TO - 1; end
            else                k = g + r;
        end
        for (int cyc = 0; cyc <= k; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check_wb();
                valid_i = v; memread_i = rd_en; memwrite_i = wr_en;
                regwrite_i = rw; memtoreg_i = mtr; funct3_i = f3;
                rd_i = rd; alu_rst_i = addr; mem_wdata_i = wdata;
            end else begin
                check("bubble_valid", valid_o, 1'b0);
                check("bubble_regwrite", regwrite_o, 1'b0);
                check("bubble_flags", {misalign_o, timeout_o}, 2'b00);
            end
            data_gnt_i    = aligned && (cyc == g);
            data_rvalid_i = (aligned && load && !to && (cyc == g + r)) ||
                            (stray && aligned && (cyc == g));
            data_i        = (aligned && load && !to && (cyc == g + r)) ? rdata : $urandom();
            #1;
            check("stall", stall_o, cyc < k);
            check("req", data_req_o, aligned && (cyc <= gc));
            if (aligned && cyc <= gc) begin
                check("addr", data_addr_o, addr & 32'hFFFF_FFFC);
                check("be", data_be_o, exp_be);
                check("we", data_we_o, wr_en);
                if (wr_en) check("wdata", data_o, exp_wd);
            end
        end
        e.valid     = v;
        e.rd        = rd;
        e.alu       = addr;
        e.misalign  = mis;
        e.timeout   = to;
        e.regwrite  = rw && v && !mis && !to;
        e.memtoreg  = mtr && v;
        e.chk_mtr   = !mis && !to;
        e.chk_rdata = aligned && load && !to;
        e.rdata     = load_val(f3, addr, rdata);
        exp_q.push_back(e);
    endtask

    task automatic reset_mid_read();
        @(negedge clk);
        check_wb();
        valid_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; regwrite_i = 1'b1;
        memtoreg_i = 1'b1; funct3_i = 3'b010; rd_i = 5'd9; alu_rst_i = 32'h200;
        data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
        #1 check("rst_issue_req", data_req_o, 1'b1);
        @(negedge clk);
        data_gnt_i = 1'b0;
        #1 check("rst_rv_stall", stall_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_rd", rd_o, 0);
        check("rst_alu", alu_rst_o, 0);
        check("rst_rdata", mem_rdata_o, 0);
        check("rst_ctrl", {memtoreg_o, regwrite_o, misalign_o, timeout_o}, 4'b0000);
        check("rst_req", data_req_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_state", state_o, 2'd0);
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b0; memread_i = 1'b0;
        data_rvalid_i = 1'b1; data_i = 32'hDEAD_BEEF;
        #1;
        check("post_rst_state", state_o, 2'd0);
        check("post_rst_stall", stall_o, 1'b0);
        @(negedge clk);
        data_rvalid_i = 1'b0;
        check("late_rv_valid", valid_o, 1'b0);
        check("late_rv_rdata", mem_rdata_o, 0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  f3;
        int          kind;
        rst = 1'b0;
        valid_i = 0; memread_i = 0; memwrite_i = 0; regwrite_i = 0; memtoreg_i = 0;
        funct3_i = 0; rd_i = 0; alu_rst_i = 0; mem_wdata_i = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_i = 0;
        @(negedge clk);
        @(negedge clk);
        check("init_valid", valid_o, 1'b0);
        check("init_wb", {rd_o, alu_rst_o, mem_rdata_o}, 0);
        check("init_req", {data_req_o, stall_o}, 2'b00);
        rst = 1'b1;

        // directed cases
        do_op(1, 0, 0, 1, 0, 3'b000, 5'd7, 32'h1234, 0, 0, 1, 0, 0);
        do_op(1, 1, 0, 1, 1, 3'b000, 5'd3, 32'h103, 0, 2, 1, 0, 32'h80FF_FF00);
        do_op(1, 1, 0, 1, 1, 3'b100, 5'd4, 32'h103, 0, 2, 1, 0, 32'h80FF_FF00);
        do_op(1, 0, 1, 0, 0, 3'b001, 5'd0, 32'h102, 32'hABCD, 0, 1, 0, 0);
        do_op(1, 1, 0, 1, 1, 3'b010, 5'd5, 32'h102, 0, 0, 1, 0, 0);
        do_op(1, 1, 0, 1, 1, 3'b011, 5'd6, 32'h100, 0, 0, 1, 0, 0);
        do_op(1, 1, 0, 1, 1, 3'b111, 5'd6, 32'h100, 0, 0, 1, 0, 0);
        do_op(1, 0, 1, 0, 0, 3'b010, 5'd0, 32'h300, 32'h5555_AAAA, 9, 1, 0, 0);
        do_op(1, 1, 0, 1, 1, 3'b010, 5'd8, 32'h304, 0, 1, 7, 1, 32'h1111_2222);
        do_op(1, 1, 0, 1, 1, 3'b101, 5'd10, 32'h306, 0, 3, 3, 1, 32'hF00F_0000);
        do_op(1, 0, 0, 1, 0, 3'b000, 5'd11, 32'hCAFE_0001, 0, 0, 1, 0, 0);
        reset_mid_read();

        // randomized ops
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 2);
            addr = $urandom();
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            do_op($urandom_range(0, 5) != 0, kind == 1, kind == 2, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), f3, 5'($urandom_range(0, 31)), addr, $urandom(),
                  $urandom_range(0, 5), $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                  $urandom());
        end
        @(negedge clk);
        check_wb();
        valid_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
